vldp_stream_feeder: RTL

VLDP_STREAM_FEEDER -- requirements
Module: vldp_stream_feeder

---
 rtl/vldp_stream_feeder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/vldp_stream_feeder.sv
// vldp_stream_feeder
// Buffers IN_W-bit words from the memory side in a small FIFO and serialises
// them into a byte stream for the decoder. A play/pause FSM gates delivery.
// A one-cycle flush state discards everything buffered. A saturating counter
// tracks delivered bytes. An underrun pulse flags starvation while streaming.

module vldp_stream_feeder #(
    parameter int IN_W      = 32,
    parameter int DEPTH     = 16,
    parameter int CNT_W     = 32,
    parameter int BYTE_SWAP = 0
) (
    input  logic                     sys_clk,
    input  logic                     RESET_N,
    input  logic                     play,
    input  logic                     flush,
    input  logic [IN_W-1:0]          in_dat,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_dat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         stream_dat_count,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    output logic [1:0]               state
);

    localparam int NB    = IN_W / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Reject parameter sets the datapath cannot represent.
    if ((IN_W < 8) || ((IN_W % 8) != 0)) begin : g_bad_in_w
        $error("vldp_stream_feeder: IN_W must be a multiple of 8 and at least 8");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("vldp_stream_feeder: DEPTH must be a power of 2 and at least 2");
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                state_q,    state_d;
    logic [PTR_W-1:0]      wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]      level_q,    level_d;
    logic [IN_W-1:0]       ser_word_q, ser_word_d;
    logic [IDX_W-1:0]      ser_idx_q,  ser_idx_d;
    logic                  ser_full_q, ser_full_d;
    logic [CNT_W-1:0]      count_q,    count_d;
    logic                  underrun_q, underrun_d;
    logic                  in_ready_q, in_ready_d;

    logic [IN_W-1:0]       mem [DEPTH];

    // ------------------------------------------------------------------
    // Handshake and control decode
    // ------------------------------------------------------------------
    logic             out_valid_w;
    logic             byte_take;
    logic             last_take;
    logic             fifo_empty;
    logic             wr_en;
    logic             rd_en;
    logic [IDX_W-1:0] byte_sel;

    // Decode the handshakes and decide FIFO write/read for this edge.
    always_comb begin
        out_valid_w = ser_full_q && (state_q == ST_RUN);
        byte_take   = out_valid_w && out_ready;
        last_take   = byte_take && (ser_idx_q == LAST_IDX);
        fifo_empty  = (level_q == '0);
        // in_ready_q already excludes full and FLUSH; flush on this edge wins
        wr_en       = in_valid && in_ready_q && !flush;
        // Serialiser reloads only while streaming, so a paused FIFO can fill to DEPTH
        rd_en       = !flush && (state_q == ST_RUN) && !fifo_empty
                      && (!ser_full_q || last_take);
    end

    // Next-state logic for the FSM, FIFO bookkeeping, serialiser and counter.
    always_comb begin
        // NOTE: every signal gets a default before any branch so this block
        // can never infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ser_word_d = ser_word_q;
        ser_idx_d  = ser_idx_q;
        ser_full_d = ser_full_q;
        count_d    = count_q;
        underrun_d = 1'b0;

        // FSM: flush outranks everything, including a held play
        if (flush) begin
            state_d = ST_FLUSH;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (play) state_d = ST_RUN;
                ST_RUN:   if (!play && !(out_valid_w && !out_ready)) state_d = ST_PAUSE;
                ST_PAUSE: if (play) state_d = ST_RUN;
                ST_FLUSH: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        if (flush) begin
            // Drop everything: buffered words, the partly sent word, the count
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            ser_word_d = '0;
            ser_idx_d  = '0;
            ser_full_d = 1'b0;
            count_d    = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);

            unique case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            // Serialiser: a reload on the last byte avoids an idle bubble
            if (rd_en) begin
                ser_word_d = mem[rd_ptr_q];
                ser_idx_d  = '0;
                ser_full_d = 1'b1;
            end else if (last_take) begin
                ser_idx_d  = '0;
                ser_full_d = 1'b0;
            end else if (byte_take) begin
                ser_idx_d  = ser_idx_q + IDX_W'(1);
            end

            if (byte_take && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_W'(1);
            end

            // Starvation only counts while actively streaming, not when pausing
            underrun_d = (state_q == ST_RUN) && play && last_take && fifo_empty;
        end

        // Registered so in_ready has no path from out_ready and is low in reset
        in_ready_d = (level_d != FULL_LVL) && (state_d != ST_FLUSH);
    end

    // Control and datapath registers, cleared asynchronously by RESET_N.
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ser_word_q <= '0;
            ser_idx_q  <= '0;
            ser_full_q <= 1'b0;
            count_q    <= '0;
            underrun_q <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ser_word_q <= ser_word_d;
            ser_idx_q  <= ser_idx_d;
            ser_full_q <= ser_full_d;
            count_q    <= count_d;
            underrun_q <= underrun_d;
            in_ready_q <= in_ready_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge sys_clk) begin
        // NOTE: the storage array has no reset; level and pointers define
        // which entries are valid, so stale contents are never observed.
        if (wr_en) begin
            mem[wr_ptr_q] <= in_dat;
        end
    end

    // Select the current byte: index 0 is the MSB byte unless BYTE_SWAP is set.
    always_comb begin
        if (BYTE_SWAP != 0) byte_sel = ser_idx_q;
        else                byte_sel = LAST_IDX - ser_idx_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_dat          = 8'(ser_word_q >> {byte_sel, 3'b000});
    assign out_valid        = out_valid_w;
    assign in_ready         = in_ready_q;
    assign stream_dat_count = count_q;
    assign level            = level_q;
    assign underrun         = underrun_q;
    assign state            = state_q;

endmodule
